// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: register addresses and writeback source select.
package mips_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter for the single register-file write port.
module wb_rr_arbiter
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    alu_valid,
  input  logic    mem_valid,
  output logic    alu_grant,
  output logic    mem_grant,
  output wb_src_e grant_src
);

  wb_src_e last_q, last_d;

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    last_d    = last_q;
    if (alu_valid && mem_valid) begin
      // Conflict: favour whichever path lost the previous conflict.
      if (last_q == WB_ALU) begin
        mem_grant = 1'b1;
        last_d    = WB_MEM;
      end else begin
        alu_grant = 1'b1;
        last_d    = WB_ALU;
      end
    end else begin
      alu_grant = alu_valid;
      mem_grant = mem_valid;
    end
    grant_src = mem_grant ? WB_MEM : WB_ALU;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= WB_ALU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// Issue-stage destination select, busy-register scoreboard with outstanding-write
// limit, and register-file write-port arbitration between ALU and load returns.
module reg_dest_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic                issue_regdst,
  input  logic                issue_regwrite,
  input  logic [ADDR_W-1:0]   issue_rs,
  input  logic [ADDR_W-1:0]   issue_rt,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic [ADDR_W-1:0]   issue_dest,
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_dest,
  output logic                alu_wb_ready,
  input  logic                mem_wb_valid,
  input  logic [ADDR_W-1:0]   mem_wb_dest,
  output logic                mem_wb_ready,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic                rf_wsel,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wb_err
);

  localparam int unsigned    CntW   = $clog2(MAX_OUT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUT);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_d;

  logic                rs_busy, rt_busy, dest_busy, hazard;
  logic                issue_set;
  logic                wb_fire, wb_nz, cnt_dec;
  logic [ADDR_W-1:0]   wb_dest;
  wb_src_e             wb_src;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_wb_valid),
    .mem_valid (mem_wb_valid),
    .alu_grant (alu_wb_ready),
    .mem_grant (mem_wb_ready),
    .grant_src (wb_src)
  );

  always_comb begin
    issue_dest  = issue_regdst ? issue_rd : issue_rt;
    // RT is always treated as a source, even for I-type instructions.
    rs_busy     = (issue_rs != REG_ZERO) && busy_q[issue_rs];
    rt_busy     = (issue_rt != REG_ZERO) && busy_q[issue_rt];
    dest_busy   = (issue_dest != REG_ZERO) && busy_q[issue_dest];
    hazard      = rs_busy || rt_busy || (issue_regwrite && dest_busy);
    issue_ready = !hazard && (cnt_q < MaxCnt);
    issue_set   = issue_valid && issue_ready && issue_regwrite && (issue_dest != REG_ZERO);

    wb_fire = alu_wb_ready || mem_wb_ready;
    wb_dest = (wb_src == WB_MEM) ? mem_wb_dest : alu_wb_dest;
    wb_nz   = wb_dest != REG_ZERO;
    cnt_dec = wb_fire && (cnt_q != '0);

    busy_d = busy_q;
    if (wb_fire && wb_nz) busy_d[wb_dest] = 1'b0;
    if (issue_set) busy_d[issue_dest] = 1'b1;

    cnt_d = cnt_q;
    if (issue_set && !cnt_dec) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!issue_set && cnt_dec) begin
      cnt_d = cnt_q - CntW'(1);
    end

    err_d = wb_err || (wb_fire && wb_nz && !busy_q[wb_dest]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      wb_err   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wsel  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      wb_err <= err_d;
      rf_we  <= wb_fire && wb_nz;
      if (wb_fire) begin
        rf_waddr <= wb_dest;
        rf_wsel  <= wb_src;
      end
    end
  end

  assign busy_vec = busy_q;

endmodule
